// File: rtl/sprite_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_pkg : shared slot type, screen constants and span helper
// Rev 1.0
// ------------------------------------------------------------------
package sprite_pkg;

  localparam int         H_ACTIVE        = 640;
  localparam int         V_ACTIVE        = 480;
  localparam int         SPR_W           = 16;
  localparam int         SPR_H           = 16;
  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_slot_t;

  // 11-bit compare so an origin near 1023 cannot wrap onto column/row 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org,
                                   input logic [10:0] len);
    logic [10:0] p;
    logic [10:0] o;
    p = {1'b0, pos};
    o = {1'b0, org};
    return (p >= o) && (p < (o + len));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_layer_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_layer_arbiter_if : pixel, config, ROM and output signal bundle
// Rev 1.0
// ------------------------------------------------------------------
interface sprite_layer_arbiter_if #(
  parameter int NUM_SPRITES = 4,
  parameter int ROM_AW      = 10
);
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [9:0]        cfg_x;
  logic [9:0]        cfg_y;
  logic              cfg_en;
  logic [ROM_AW-1:0] rom_address;
  logic [3:0]        rom_q;
  logic [3:0]        pix_index;
  logic              pix_hit;
  logic              blank_d;
  logic              frame_tick;

  modport slave (
    input  DrawX, DrawY, blank, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, rom_q,
    output rom_address, pix_index, pix_hit, blank_d, frame_tick
  );

  modport master (
    output DrawX, DrawY, blank, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, rom_q,
    input  rom_address, pix_index, pix_hit, blank_d, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/sprite_hit_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_hit_encoder : per-slot box test and fixed-priority winner pick
// Rev 1.0
// ------------------------------------------------------------------
module sprite_hit_encoder
  import sprite_pkg::sprite_slot_t, sprite_pkg::in_span;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  parameter int XW          = $clog2(SPR_W),
  parameter int YW          = $clog2(SPR_H)
) (
  input  sprite_slot_t [NUM_SPRITES-1:0] slots,
  input  logic [9:0]                     draw_x,
  input  logic [9:0]                     draw_y,
  input  logic                           blank,
  output logic                           hit,
  output logic [SEL_W-1:0]               sel,
  output logic [XW-1:0]                  off_x,
  output logic [YW-1:0]                  off_y
);

  logic [NUM_SPRITES-1:0] slot_hit;

  generate
    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_box
      assign slot_hit[i] = slots[i].en && blank &&
                           in_span(draw_x, slots[i].x, 11'(SPR_W)) &&
                           in_span(draw_y, slots[i].y, 11'(SPR_H));
    end
  endgenerate

  // Walk from lowest priority upward so slot 0 overrides everything.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
    off_x = XW'(draw_x - slots[sel].x);
    off_y = YW'(draw_y - slots[sel].y);
  end

endmodule
`default_nettype wire

// File: rtl/sprite_layer_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_layer_arbiter : per-pixel sprite arbitration over a shared ROM
// Rev 1.0
// ------------------------------------------------------------------
module sprite_layer_arbiter
  import sprite_pkg::sprite_slot_t;
#(
  parameter int         NUM_SPRITES     = 4,
  parameter int         SPR_W           = sprite_pkg::SPR_W,
  parameter int         SPR_H           = sprite_pkg::SPR_H,
  parameter int         ROM_AW          = 10,
  parameter logic [3:0] TRANSPARENT_IDX = sprite_pkg::TRANSPARENT_IDX,
  parameter int         COMMIT_Y        = sprite_pkg::V_ACTIVE
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  sprite_layer_arbiter_if.slave  bus
);

  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int XW    = $clog2(SPR_W);
  localparam int YW    = $clog2(SPR_H);

  sprite_slot_t [NUM_SPRITES-1:0] shadow_q, shadow_d;
  sprite_slot_t [NUM_SPRITES-1:0] active_q, active_d;

  logic              frame_tick_q, frame_tick_d;
  logic [ROM_AW-1:0] rom_address_q, rom_address_d;
  logic              hit_s1_q, hit_s1_d;
  logic              blank_s1_q, blank_s1_d;
  logic              hit_s2_q, hit_s2_d;
  logic              blank_s2_q, blank_s2_d;
  logic [3:0]        pix_index_q, pix_index_d;
  logic              pix_hit_q, pix_hit_d;
  logic              blank_d_q, blank_d_d;

  logic              commit;
  logic              enc_hit;
  logic [SEL_W-1:0]  enc_sel;
  logic [XW-1:0]     enc_off_x;
  logic [YW-1:0]     enc_off_y;

  sprite_hit_encoder #(
    .NUM_SPRITES (NUM_SPRITES),
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .SEL_W       (SEL_W),
    .XW          (XW),
    .YW          (YW)
  ) u_hit_encoder (
    .slots  (active_q),
    .draw_x (bus.DrawX),
    .draw_y (bus.DrawY),
    .blank  (bus.blank),
    .hit    (enc_hit),
    .sel    (enc_sel),
    .off_x  (enc_off_x),
    .off_y  (enc_off_y)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (bus.cfg_we && (int'(bus.cfg_sel) < NUM_SPRITES)) begin
      shadow_d[bus.cfg_sel] = {bus.cfg_en, bus.cfg_x, bus.cfg_y};
    end

    // Commit from shadow_d so a same-cycle write lands in this frame's set.
    commit       = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(COMMIT_Y));
    active_d     = commit ? shadow_d : active_q;
    frame_tick_d = commit;

    // Power-of-2 sprite size makes the address a plain field concatenation.
    rom_address_d = enc_hit ? ROM_AW'({enc_sel, enc_off_y, enc_off_x}) : '0;
    hit_s1_d      = enc_hit;
    blank_s1_d    = bus.blank;

    hit_s2_d      = hit_s1_q;
    blank_s2_d    = blank_s1_q;

    pix_index_d   = hit_s2_q ? bus.rom_q : 4'd0;
    pix_hit_d     = hit_s2_q && (bus.rom_q != TRANSPARENT_IDX);
    blank_d_d     = blank_s2_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q      <= '0;
      active_q      <= '0;
      frame_tick_q  <= 1'b0;
      rom_address_q <= '0;
      hit_s1_q      <= 1'b0;
      blank_s1_q    <= 1'b0;
      hit_s2_q      <= 1'b0;
      blank_s2_q    <= 1'b0;
      pix_index_q   <= 4'd0;
      pix_hit_q     <= 1'b0;
      blank_d_q     <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_tick_q  <= frame_tick_d;
      rom_address_q <= rom_address_d;
      hit_s1_q      <= hit_s1_d;
      blank_s1_q    <= blank_s1_d;
      hit_s2_q      <= hit_s2_d;
      blank_s2_q    <= blank_s2_d;
      pix_index_q   <= pix_index_d;
      pix_hit_q     <= pix_hit_d;
      blank_d_q     <= blank_d_d;
    end
  end

  assign bus.rom_address = rom_address_q;
  assign bus.pix_index   = pix_index_q;
  assign bus.pix_hit     = pix_hit_q;
  assign bus.blank_d     = blank_d_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule
`default_nettype wire

// File: doc/sprite_layer_arbiter.md
Name: sprite_layer_arbiter

Overview:
- Shares one sprite ROM (4-bit palette indices) among NUM_SPRITES on-screen objects, such as tanks, bullets and score digits, on a per-pixel basis.
- For every pixel it picks the highest-priority sprite covering (DrawX, DrawY), generates the ROM address and returns the palette index, pipeline-aligned with a delayed blank.
- Sprite positions and enables come from game logic through a shadow-register write port. They are committed to the active set once per frame so a sprite never tears mid-frame.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; slot 0 has the highest priority.
- SPR_W, 16, sprite width in pixels (power of 2).
- SPR_H, 16, sprite height in pixels (power of 2).
- ROM_AW, 10, ROM address width; must be at least log2(NUM_SPRITES*SPR_W*SPR_H).
- TRANSPARENT_IDX, 0, palette index treated as transparent.
- COMMIT_Y, 480, first vblank line; position commit happens at DrawX==0 on this line.

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- cfg_we  in  1  shadow-register write strobe.
- cfg_sel  in  $clog2(NUM_SPRITES)  slot to write.
- cfg_x  in  10  sprite left edge.
- cfg_y  in  10  sprite top edge.
- cfg_en  in  1  slot visible.
- rom_address  out  ROM_AW  address to shared sprite ROM; ROM has 1-cycle registered read.
- rom_q  in  4  ROM data.
- pix_index  out  4  palette index of winning sprite.
- pix_hit  out  1  1 = opaque sprite pixel present, so downstream shows pix_index instead of background.
- blank_d  out  1  blank delayed to align with pix_index and pix_hit.
- frame_tick  out  1  one-cycle pulse on each commit.

Behaviour:
- Reset (async, reset_n=0):
  - All shadow and active slots are cleared: en=0, x=0, y=0.
  - rom_address=0, pix_index=0, pix_hit=0, blank_d=0, frame_tick=0.
  - All pipeline valid/hit bits are cleared; reset mid-frame simply discards in-flight pixels.
- Config write: on a cycle with cfg_we=1, shadow[cfg_sel] gets {cfg_en, cfg_x, cfg_y}.
  - No backpressure; writes are accepted on every cycle.
  - cfg_sel >= NUM_SPRITES is ignored.
- Commit: on the cycle where DrawX==0 and DrawY==COMMIT_Y, active <= shadow for all slots, and frame_tick=1 on the following cycle.
  - If cfg_we is asserted in the commit cycle, that write is included in the committed value (write-through).
- Hit test (stage 0, combinational on inputs and active regs):
  - Slot i hits when en_i, blank=1, x_i <= DrawX < x_i+SPR_W and y_i <= DrawY < y_i+SPR_H.
  - Comparisons use 11-bit arithmetic, so sprites near x=1023 or y=1023 do not wrap. Sprites partially beyond 639/479 clip naturally.
  - Winner is the lowest-index hitting slot, via a fixed-priority encoder.
- Stage 1 register:
  - rom_address <= sel*SPR_W*SPR_H + (DrawY-y_sel)*SPR_W + (DrawX-x_sel), with offsets truncated to log2(SPR_W) and log2(SPR_H) bits.
  - hit_s1 <= any hit; blank_s1 <= blank.
  - With no hit, rom_address holds 0 and hit_s1=0.
- Stage 2 register: hit_s2 and blank_s2 follow stage 1, matching the ROM read cycle.
- Stage 3 register (output):
  - pix_index <= rom_q; blank_d <= blank_s2.
  - pix_hit <= hit_s2 and (rom_q != TRANSPARENT_IDX).
  - When hit_s2=0, pix_index <= 0.
- Latency: pixel inputs on cycle N appear on pix_index, pix_hit and blank_d at cycle N+3, with fixed throughput of 1 pixel per clock.
- Transparency: a transparent pixel of the winning sprite yields pix_hit=0 and does not fall through to a lower-priority sprite. This is accepted because there is only one ROM fetch per pixel.
- A commit occurring while pixels are in the pipeline does not alter those in-flight pixels.

Decomposition:
- Shared package sprite_pkg holds:
  - typedef sprite_slot_t {logic en; logic [9:0] x; logic [9:0] y;}
  - constants H_ACTIVE=640, V_ACTIVE=480, SPR_W, SPR_H, TRANSPARENT_IDX.
- Sub-module sprite_hit_encoder: combinational per-slot box test plus fixed-priority encoder. It outputs hit, sel and the x/y offsets.

Test Plan:
- Reset: assert reset_n=0 mid-line → all outputs 0 immediately. After release with no cfg writes, pix_hit stays 0 for a full frame.
- Single sprite:
  - Stimulus: write slot 1 {en=1, x=100, y=50}, run to commit, sweep DrawX/Y.
  - Address check: at DrawX=105, DrawY=53, rom_address = 256+3*16+5 = 309 one cycle later.
  - Output check: pix_index = ROM word 309 three cycles after the pixel. pix_hit=1 only for x 100..115, y 50..65.
- Priority: slots 0 and 2 both at (200,200) → rom_address uses base 0, never 512. Disabling slot 0 (then commit) → base 512.
- Transparency and blank:
  - ROM word 0 = TRANSPARENT_IDX → pix_hit=0 and pix_index=0 at the sprite origin.
  - blank=0 over a sprite area → pix_hit=0, and blank_d tracks blank delayed by 3.
- Commit timing:
  - A write mid-frame (DrawY=240) to x=300 leaves the sprite at its old x until DrawY=COMMIT_Y.
  - A write exactly on the commit cycle takes effect next frame.
  - frame_tick pulses once per frame.
- Edge clipping: sprite at x=632 → hits only for DrawX 632..639. Sprite at x=1020 → no hits (no 10-bit wrap to DrawX 0..11).
